// File: rtl/online_mul_arbiter.sv
// Round-robin owner of one shared digit-serial online multiplier for two requesters.
// Latency: operand/product digits pass combinationally; grant one cycle after request.
// Backpressure: operand and product handshakes stall freely; the op completes on the NDIG-th product digit.
module online_mul_arbiter #(
    parameter int NDIG  = 8,
    parameter int DELTA = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_vd,
    input  logic [1:0] req0_x,
    input  logic [1:0] req0_y,
    output logic       req0_rd,
    output logic [1:0] req0_p,
    output logic       req0_p_vd,
    input  logic       req0_p_rd,
    input  logic       req1_vd,
    input  logic [1:0] req1_x,
    input  logic [1:0] req1_y,
    output logic       req1_rd,
    output logic [1:0] req1_p,
    output logic       req1_p_vd,
    input  logic       req1_p_rd,
    output logic [1:0] mul_x,
    output logic [1:0] mul_y,
    output logic       mul_in_vd,
    input  logic       mul_in_rd,
    input  logic [1:0] mul_p,
    input  logic       mul_out_vd,
    output logic       mul_out_rd,
    output logic [1:0] grant,
    output logic       busy,
    output logic       op_done,
    output logic       err
);
    localparam int CW = $clog2(NDIG + DELTA + 1);
    localparam logic [CW-1:0] N_DIG   = CW'(NDIG);
    localparam logic [CW-1:0] IN_LAST = CW'(NDIG + DELTA);

    typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant_nxt;
    logic          ptr, ptr_nxt;
    logic [CW-1:0] in_cnt, in_cnt_nxt;
    logic [CW-1:0] out_cnt, out_cnt_nxt;
    logic          err_nxt;

    logic          g_vd;
    logic          g_p_rd;
    logic [1:0]    g_x, g_y;
    logic          in_hs, out_hs;

    always_comb begin
        g_vd   = grant[1] ? req1_vd   : req0_vd;
        g_x    = grant[1] ? req1_x    : req0_x;
        g_y    = grant[1] ? req1_y    : req0_y;
        g_p_rd = grant[1] ? req1_p_rd : req0_p_rd;
    end

    // Datapath routing is gated by state so IDLE/DONE (and reset) drive all zeros.
    always_comb begin
        mul_x      = 2'b00;
        mul_y      = 2'b00;
        mul_in_vd  = 1'b0;
        mul_out_rd = 1'b0;
        req0_rd    = 1'b0;
        req1_rd    = 1'b0;
        req0_p     = 2'b00;
        req1_p     = 2'b00;
        req0_p_vd  = 1'b0;
        req1_p_vd  = 1'b0;
        if (state == FEED) begin
            if (in_cnt < N_DIG) begin
                mul_x     = (g_x == 2'b11) ? 2'b00 : g_x;
                mul_y     = (g_y == 2'b11) ? 2'b00 : g_y;
                mul_in_vd = g_vd;
                req0_rd   = grant[0] & mul_in_rd & req0_vd;
                req1_rd   = grant[1] & mul_in_rd & req1_vd;
            end else if (in_cnt < IN_LAST) begin
                mul_in_vd = 1'b1;
            end
            mul_out_rd = g_p_rd;
            req0_p     = grant[0] ? mul_p : 2'b00;
            req1_p     = grant[1] ? mul_p : 2'b00;
            req0_p_vd  = grant[0] & mul_out_vd;
            req1_p_vd  = grant[1] & mul_out_vd;
        end
    end

    assign in_hs   = mul_in_vd & mul_in_rd;
    assign out_hs  = mul_out_vd & mul_out_rd;
    assign busy    = (state != IDLE);
    assign op_done = (state == DONE);

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        err_nxt     = err;
        if (mul_out_vd && (state != FEED)) begin
            err_nxt = 1'b1;
        end
        case (state)
            IDLE: begin
                if (req0_vd || req1_vd) begin
                    // ptr=0 favours requester 0, ptr=1 favours requester 1
                    if (req0_vd && (!req1_vd || !ptr)) begin
                        grant_nxt = 2'b01;
                    end else begin
                        grant_nxt = 2'b10;
                    end
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                    state_nxt   = FEED;
                end
            end
            FEED: begin
                if (in_hs) begin
                    in_cnt_nxt = in_cnt + 1'b1;
                end
                if (out_hs) begin
                    if (out_cnt >= N_DIG) begin
                        err_nxt = 1'b1;
                    end else begin
                        out_cnt_nxt = out_cnt + 1'b1;
                    end
                    if (out_cnt == N_DIG - 1'b1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                grant_nxt = 2'b00;
                ptr_nxt   = grant[0];
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 2'b00;
            ptr     <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
            err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_online_mul_arbiter.sv
// Bench for online_mul_arbiter: the bench plays both requesters and the shared multiplier,
// with queues holding the operand and product digits expected at the far side.
module tb_online_mul_arbiter;
    localparam int NDIG  = 8;
    localparam int DELTA = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_vd, req1_vd, req0_rd, req1_rd;
    logic [1:0] req0_x, req0_y, req1_x, req1_y;
    logic [1:0] req0_p, req1_p;
    logic       req0_p_vd, req1_p_vd, req0_p_rd, req1_p_rd;
    logic [1:0] mul_x, mul_y, mul_p;
    logic       mul_in_vd, mul_in_rd, mul_out_vd, mul_out_rd;
    logic [1:0] grant;
    logic       busy, op_done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] op_x [NDIG];
    logic [1:0] op_y [NDIG];
    logic [1:0] prod [NDIG];
    logic [3:0] in_q [$];
    logic [1:0] p_q  [$];

    always #5 clk = ~clk;

    online_mul_arbiter #(.NDIG(NDIG), .DELTA(DELTA)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vd(req0_vd), .req0_x(req0_x), .req0_y(req0_y), .req0_rd(req0_rd),
        .req0_p(req0_p), .req0_p_vd(req0_p_vd), .req0_p_rd(req0_p_rd),
        .req1_vd(req1_vd), .req1_x(req1_x), .req1_y(req1_y), .req1_rd(req1_rd),
        .req1_p(req1_p), .req1_p_vd(req1_p_vd), .req1_p_rd(req1_p_rd),
        .mul_x(mul_x), .mul_y(mul_y), .mul_in_vd(mul_in_vd), .mul_in_rd(mul_in_rd),
        .mul_p(mul_p), .mul_out_vd(mul_out_vd), .mul_out_rd(mul_out_rd),
        .grant(grant), .busy(busy), .op_done(op_done), .err(err)
    );

    function automatic logic [1:0] sd(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    task automatic do_reset();
        req0_vd = 0; req0_x = 0; req0_y = 0; req0_p_rd = 0;
        req1_vd = 0; req1_x = 0; req1_y = 0; req1_p_rd = 0;
        mul_in_rd = 0; mul_p = 0; mul_out_vd = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic fill_ops(input bit all_ones);
        for (int i = 0; i < NDIG; i++) begin
            op_x[i] = all_ones ? 2'b11 : 2'($urandom_range(0, 3));
            op_y[i] = all_ones ? 2'b11 : 2'($urandom_range(0, 3));
            prod[i] = 2'($urandom_range(0, 2));
        end
    endtask

    // One full operation for requester `who`; the other may hold vd high to contend.
    // Multiplier model: product digit k is offered once k+DELTA+1 operand digits were taken.
    task automatic run_op(input int who, input bit hold_other, input bit stall);
        int sent = 0, acc_in = 0, flush = 0, prod_sent = 0, got = 0, dones = 0, cyc = 0;
        bit done_seen = 0, fin = 0;
        logic v, o, p_rd, w_rd, w_pvd, o_rd, o_pvd;
        logic [1:0] w_p, o_p, ep;
        logic [3:0] e;
        in_q.delete();
        p_q.delete();
        while (!fin && cyc < 300) begin
            @(posedge clk);
            #1;
            v = (!done_seen && sent < NDIG) ? ((stall && cyc > 0) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            o = !done_seen && hold_other;
            p_rd = !(stall && cyc >= 8 && cyc < 13);
            if (who == 0) begin
                req0_vd = v; req0_x = op_x[sent % NDIG]; req0_y = op_y[sent % NDIG]; req0_p_rd = p_rd;
                req1_vd = o; req1_x = 2'b10; req1_y = 2'b01; req1_p_rd = 1'b1;
            end else begin
                req1_vd = v; req1_x = op_x[sent % NDIG]; req1_y = op_y[sent % NDIG]; req1_p_rd = p_rd;
                req0_vd = o; req0_x = 2'b10; req0_y = 2'b01; req0_p_rd = 1'b1;
            end
            mul_in_rd  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            mul_out_vd = (prod_sent < NDIG) && (acc_in >= prod_sent + DELTA + 1);
            mul_p      = mul_out_vd ? prod[prod_sent % NDIG] : 2'b00;
            @(negedge clk);
            w_rd  = (who == 0) ? req0_rd   : req1_rd;
            w_pvd = (who == 0) ? req0_p_vd : req1_p_vd;
            w_p   = (who == 0) ? req0_p    : req1_p;
            o_rd  = (who == 0) ? req1_rd   : req0_rd;
            o_pvd = (who == 0) ? req1_p_vd : req0_p_vd;
            o_p   = (who == 0) ? req1_p    : req0_p;
            if (cyc == 0) begin
                n_cmp++;
                if ({grant, busy} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL pre_grant: grant/busy=%b want 000", {grant, busy});
                end
            end
            if (cyc == 1) begin
                n_cmp++;
                if ({grant, busy} !== {2'(1 << who), 1'b1}) begin
                    n_bad++;
                    $display("FAIL grant_latency: grant/busy=%b want %b", {grant, busy}, {2'(1 << who), 1'b1});
                end
            end
            n_cmp++;
            if ({o_rd, o_pvd, o_p} !== 4'b0000) begin
                n_bad++;
                $display("FAIL other_quiet cyc%0d: rd/p_vd/p=%b want 0000", cyc, {o_rd, o_pvd, o_p});
            end
            if (v && w_rd) begin
                in_q.push_back({sd(op_x[sent]), sd(op_y[sent])});
                sent++;
            end
            if (mul_in_vd && mul_in_rd) begin
                if (in_q.size() > 0) begin
                    e = in_q.pop_front();
                end else begin
                    e = 4'b0000;
                    flush++;
                end
                n_cmp++;
                if ({mul_x, mul_y} !== e) begin
                    n_bad++;
                    $display("FAIL operand_digit %0d: mul_x/y=%b want %b", acc_in, {mul_x, mul_y}, e);
                end
                acc_in++;
            end
            if (mul_out_vd && mul_out_rd) begin
                p_q.push_back(prod[prod_sent]);
                prod_sent++;
            end
            if (w_pvd && p_rd) begin
                ep = (p_q.size() > 0) ? p_q.pop_front() : 2'bxx;
                n_cmp++;
                if (w_p !== ep) begin
                    n_bad++;
                    $display("FAIL product_digit %0d: p=%b want %b", got, w_p, ep);
                end
                got++;
            end
            if (op_done) begin
                dones++;
                done_seen = 1;
            end else if (done_seen && !busy) begin
                fin = 1;
            end
            cyc++;
        end
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL op_timeout: req%0d op unfinished after %0d cycles, want completion", who, cyc);
        end
        n_cmp++;
        if (acc_in != NDIG + DELTA || flush != DELTA || sent != NDIG) begin
            n_bad++;
            $display("FAIL in_count: in/flush/req=%0d/%0d/%0d want %0d/%0d/%0d",
                     acc_in, flush, sent, NDIG + DELTA, DELTA, NDIG);
        end
        n_cmp++;
        if (got != NDIG || prod_sent != NDIG || dones != 1) begin
            n_bad++;
            $display("FAIL out_count: delivered/taken/op_done=%0d/%0d/%0d want %0d/%0d/1",
                     got, prod_sent, dones, NDIG, NDIG);
        end
        n_cmp++;
        if (grant !== 2'b00) begin
            n_bad++;
            $display("FAIL grant_release: grant=%b want 00", grant);
        end
        if (!stall) begin
            n_cmp++;
            if (cyc != NDIG + DELTA + 4) begin
                n_bad++;
                $display("FAIL throughput: op took %0d cycles want %0d", cyc, NDIG + DELTA + 4);
            end
        end
        req0_vd = 0;
        req1_vd = 0;
        mul_out_vd = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({grant, busy, op_done, err, mul_in_vd, mul_out_rd, req0_rd, req1_rd} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_state: %b want 0", {grant, busy, op_done, err, mul_in_vd, mul_out_rd, req0_rd, req1_rd});
        end
        @(posedge clk);
        #1;
        req0_vd = 1; req0_x = 2'b10; req0_y = 2'b01; req0_p_rd = 1; mul_in_rd = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, mul_in_vd} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_prefeed: busy/mul_in_vd=%b want 11", {busy, mul_in_vd});
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if ({grant, busy, op_done, err, mul_in_vd, mul_x, mul_y, req0_rd, req0_p_vd, req0_p, mul_out_rd} !== 15'b0) begin
            n_bad++;
            $display("FAIL reset_async: outputs=%b want 0",
                     {grant, busy, op_done, err, mul_in_vd, mul_x, mul_y, req0_rd, req0_p_vd, req0_p, mul_out_rd});
        end
        req0_vd = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({grant, busy, err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_release: grant/busy/err=%b want 0000", {grant, busy, err});
        end
    endtask

    task automatic test_single();
        do_reset();
        fill_ops(0);
        run_op(0, 0, 0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_err: err=%b want 0", err);
        end
    endtask

    task automatic test_contention();
        do_reset();
        fill_ops(0);
        run_op(0, 1, 0);
        fill_ops(0);
        run_op(1, 1, 0);
        fill_ops(0);
        run_op(0, 1, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fill_ops(0);
            run_op(1, 0, 0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fill_ops(0);
            run_op(0, 0, 1);
        end
    endtask

    task automatic test_encoding();
        do_reset();
        fill_ops(1);
        run_op(0, 0, 0);
    endtask

    task automatic test_error();
        do_reset();
        @(posedge clk);
        #1;
        mul_out_vd = 1;
        mul_p = 2'b10;
        @(posedge clk);
        #1;
        mul_out_vd = 0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_idle: err=%b want 1", err);
        end
        fill_ops(0);
        run_op(0, 0, 0);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b want 1", err);
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_stall();
        test_encoding();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
